// File: rtl/leb128_pkg.sv
// rtl/leb128_pkg.sv - shared state, error codes and length limits for the LEB128 fetch stage
package leb128_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, DECODE, DONE} state_e;

  typedef enum logic [1:0] {
    LEB_OK       = 2'd0,
    LEB_MEM      = 2'd1,
    LEB_TOO_LONG = 2'd2,
    LEB_OVERFLOW = 2'd3
  } leb_err_e;

  localparam logic [3:0] LEB_MAXB32 = 4'd5;
  localparam logic [3:0] LEB_MAXB64 = 4'd10;
endpackage

// File: rtl/leb128_byte_step.sv
// rtl/leb128_byte_step.sv - folds one LEB128 byte into the accumulator
// Range checks and sign fill only apply when this byte terminates the encoding.
module leb128_byte_step
  import leb128_pkg::*;
(
  input  logic [63:0] acc_i,
  input  logic [6:0]  shift_i,
  input  logic [7:0]  byte_i,
  input  logic        is_last_allowed_i,
  input  logic        signed_i,
  input  logic        is64_i,
  output logic [63:0] acc_o,
  output logic        done_o,
  output logic [1:0]  err_o
);
  logic [6:0]  shift_next;
  logic [6:0]  width;
  logic [63:0] fill;
  logic        range_ok;

  always_comb begin
    shift_next = shift_i + 7'd7;
    width      = is64_i ? 7'd64 : 7'd32;
    fill       = '0;
    if (signed_i && byte_i[6] && (shift_next < width)) begin
      fill = ~((64'd1 << shift_next) - 64'd1);
    end
    if (!is64_i) begin
      fill[63:32] = '0;
    end

    // Bits of the final allowed byte that land above the target width must be pure sign/zero.
    case ({signed_i, is64_i})
      2'b00:   range_ok = (byte_i[6:4] == 3'd0);
      2'b10:   range_ok = (byte_i[6:3] == 4'h0) || (byte_i[6:3] == 4'hF);
      2'b01:   range_ok = (byte_i[6:1] == 6'd0);
      default: range_ok = (byte_i[6:0] == 7'h00) || (byte_i[6:0] == 7'h7F);
    endcase

    acc_o = acc_i | ({57'd0, byte_i[6:0]} << shift_i);
    if (!byte_i[7]) begin
      acc_o = acc_o | fill;
    end

    done_o = !byte_i[7] || is_last_allowed_i;
    err_o  = LEB_OK;
    if (is_last_allowed_i) begin
      if (byte_i[7]) begin
        err_o = LEB_TOO_LONG;
      end else if (!range_ok) begin
        err_o = LEB_OVERFLOW;
      end
    end
  end
endmodule

// File: rtl/leb128_fetch.sv
// rtl/leb128_fetch.sv - fetches a LEB128 immediate from genrom and decodes it
// LEB128_FAST_EN selects a single-cycle decode of the whole window instead of one byte per cycle.
module leb128_fetch
  import leb128_pkg::*;
#(
  parameter int MEM_DEPTH = 6,
  parameter int MEM_EXTRA = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic [MEM_DEPTH:0]          req_addr,
  input  logic                        req_signed,
  input  logic                        req_64,
  output logic [MEM_DEPTH:0]          mem_addr,
  output logic [MEM_EXTRA-1:0]        mem_extra,
  input  logic [(2**MEM_EXTRA)*8-1:0] mem_data,
  input  logic                        mem_error,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [63:0]                 rsp_value,
  output logic [3:0]                  rsp_len,
  output logic [1:0]                  rsp_error
);
  localparam int WIN_BITS = (2**MEM_EXTRA) * 8;

  state_e               state_q, state_d;
  logic                 signed_q, signed_d;
  logic                 is64_q, is64_d;
  logic [MEM_DEPTH:0]   mem_addr_q, mem_addr_d;
  logic [MEM_EXTRA-1:0] mem_extra_q, mem_extra_d;
  logic [79:0]          win_q, win_d;
  logic [63:0]          value_q, value_d;
  logic [3:0]           len_q, len_d;
  leb_err_e             err_q, err_d;

  logic [3:0]  maxb_req, maxb;
  logic        dec_done;
  logic [63:0] dec_acc;
  leb_err_e    dec_err;
  logic [3:0]  dec_len;
  logic        unused_win;

  assign maxb_req   = req_64 ? LEB_MAXB64 : LEB_MAXB32;
  assign maxb       = is64_q ? LEB_MAXB64 : LEB_MAXB32;
  assign unused_win = ^mem_data[WIN_BITS-1:80];

`ifdef LEB128_FAST_EN
  logic [10:0][63:0] chain;
  logic [9:0]        step_done;
  logic [9:0][1:0]   step_err;

  assign chain[0] = '0;
  for (genvar i = 0; i < 10; i++) begin : g_step
    leb128_byte_step u_step (
      .acc_i             (chain[i]),
      .shift_i           (7'(7 * i)),
      .byte_i            (win_q[8*i +: 8]),
      .is_last_allowed_i (4'(i + 1) == maxb),
      .signed_i          (signed_q),
      .is64_i            (is64_q),
      .acc_o             (chain[i+1]),
      .done_o            (step_done[i]),
      .err_o             (step_err[i])
    );
  end

  // Lowest terminating byte wins; step MAXB-1 always reports done.
  always_comb begin
    dec_done = 1'b1;
    dec_acc  = chain[10];
    dec_err  = LEB_OK;
    dec_len  = 4'd10;
    for (int i = 9; i >= 0; i--) begin
      if (step_done[i]) begin
        dec_acc = chain[i+1];
        dec_err = leb_err_e'(step_err[i]);
        dec_len = 4'(i + 1);
      end
    end
  end
`else
  logic [63:0] acc_q, acc_d;
  logic [6:0]  shift_q, shift_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [7:0]  cur_byte;
  logic [63:0] step_acc;
  logic [1:0]  step_err;

  assign cur_byte = win_q[8*cnt_q +: 8];

  leb128_byte_step u_step (
    .acc_i             (acc_q),
    .shift_i           (shift_q),
    .byte_i            (cur_byte),
    .is_last_allowed_i ((cnt_q + 4'd1) == maxb),
    .signed_i          (signed_q),
    .is64_i            (is64_q),
    .acc_o             (step_acc),
    .done_o            (dec_done),
    .err_o             (step_err)
  );

  assign dec_acc = step_acc;
  assign dec_err = leb_err_e'(step_err);
  assign dec_len = cnt_q + 4'd1;

  always_comb begin
    acc_d   = acc_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    if (state_q == WAIT) begin
      acc_d   = '0;
      shift_d = '0;
      cnt_d   = '0;
    end else if (state_q == DECODE) begin
      acc_d   = step_acc;
      shift_d = shift_q + 7'd7;
      cnt_d   = cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q   <= '0;
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      acc_q   <= acc_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_valid) state_d = WAIT;
      WAIT:    state_d = mem_error ? DONE : DECODE;
      DECODE:  if (dec_done) state_d = DONE;
      default: if (rsp_ready) state_d = IDLE;
    endcase
  end

  always_comb begin
    signed_d    = signed_q;
    is64_d      = is64_q;
    mem_addr_d  = mem_addr_q;
    mem_extra_d = mem_extra_q;
    win_d       = win_q;
    value_d     = value_q;
    len_d       = len_q;
    err_d       = err_q;
    if ((state_q == IDLE) && req_valid) begin
      signed_d    = req_signed;
      is64_d      = req_64;
      mem_addr_d  = req_addr;
      mem_extra_d = MEM_EXTRA'(maxb_req - 4'd1);
    end else if (state_q == WAIT) begin
      win_d = mem_data[79:0];
      if (mem_error) begin
        err_d   = LEB_MEM;
        len_d   = '0;
        value_d = '0;
      end
    end else if ((state_q == DECODE) && dec_done) begin
      err_d = dec_err;
      len_d = dec_len;
      if (dec_err != LEB_OK) begin
        value_d = '0;
      end else begin
        value_d = is64_q ? dec_acc : {32'd0, dec_acc[31:0]};
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      signed_q    <= 1'b0;
      is64_q      <= 1'b0;
      mem_addr_q  <= '0;
      mem_extra_q <= '0;
      win_q       <= '0;
      value_q     <= '0;
      len_q       <= '0;
      err_q       <= LEB_OK;
    end else begin
      signed_q    <= signed_d;
      is64_q      <= is64_d;
      mem_addr_q  <= mem_addr_d;
      mem_extra_q <= mem_extra_d;
      win_q       <= win_d;
      value_q     <= value_d;
      len_q       <= len_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    req_ready = (state_q == IDLE);
    rsp_valid = (state_q == DONE);
    mem_addr  = mem_addr_q;
    mem_extra = mem_extra_q;
    rsp_value = value_q;
    rsp_len   = len_q;
    rsp_error = err_q;
  end
endmodule

// File: doc/leb128_fetch.md
Name: leb128_fetch

Overview:
- Immediate-fetch stage between the genrom instruction ROM and the core's opcode decoder.
- Given a byte address, it fetches a LEB128-encoded immediate from ROM and decodes it. Encoding is unsigned or signed, 32- or 64-bit.
- Returns the value, the encoded byte length and an error code over a valid/ready handshake.
- Used for br_table counts and targets, local/global indices, i32.const/i64.const and memarg immediates.

Parameters:
- MEM_DEPTH, 6, ROM address width minus one; address buses are MEM_DEPTH+1 bits, matching the core's MEM_DEPTH.
- MEM_EXTRA, 4, ROM window exponent; the window is 2**MEM_EXTRA bytes and must be >= 10.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  decode request
- req_ready  out  1  high only in IDLE
- req_addr  in  MEM_DEPTH+1  byte address of the first LEB byte
- req_signed  in  1  1 = signed LEB128, 0 = unsigned
- req_64  in  1  1 = 64-bit target, 0 = 32-bit
- mem_addr  out  MEM_DEPTH+1  to genrom addr
- mem_extra  out  MEM_EXTRA  to genrom extra
- mem_data  in  2**MEM_EXTRA*8  genrom window; byte k = mem_data[8k+7:8k]
- mem_error  in  1  genrom bounds error
- rsp_valid  out  1  response held until rsp_ready
- rsp_ready  in  1  consumer accept
- rsp_value  out  64  decoded value
- rsp_len  out  4  encoded bytes consumed, 1..10
- rsp_error  out  2  0 OK, 1 MEM, 2 TOO_LONG, 3 OVERFLOW

Behaviour:
- Reset (async, any state): state IDLE, rsp_valid=0, rsp_value=0, rsp_len=0, rsp_error=0, mem_addr=0, mem_extra=0. Any in-flight request is dropped and no response is produced.
- MAXB = 10 if req_64, else 5. Request fields are latched on the accept.
- IDLE: req_ready=1. On req_valid, latch fields and drive mem_addr=req_addr and mem_extra=MAXB-1 (registered), then go to WAIT.
- WAIT, one cycle (genrom has 1-cycle latency):
  - Latch the mem_data window.
  - If mem_error=1, go to DONE with rsp_error=MEM, rsp_len=0, rsp_value=0.
  - Otherwise clear acc, shift and cnt, then go to DECODE.
- DECODE, one byte per cycle, b = byte cnt:
  - acc |= b[6:0] << shift; shift += 7; cnt += 1.
  - If b[7]=0, this is the final byte. Range check on the final byte when cnt+1 == MAXB:
    - u32: b[6:4] must be 0.
    - s32: b[6:3] all equal.
    - u64: b[6:1] must be 0.
    - s64: b[6:0] must be 0x00 or 0x7F.
    - Violation gives OVERFLOW.
  - Sign extension: if signed, b[6]=1 and shift < width, fill acc bits [width-1:shift] with 1.
  - If b[7]=1 and cnt+1 == MAXB, the error is TOO_LONG.
  - Go to DONE with rsp_len=cnt+1.
- 32-bit results occupy rsp_value[31:0]; rsp_value[63:32]=0 for both signed and unsigned. On any error, rsp_value=0.
- DONE: rsp_valid=1 and outputs stable. A cycle with rsp_valid & rsp_ready returns to IDLE. A new request is accepted no earlier than the following cycle.
- Latency from accept to rsp_valid: 2+n cycles, n = bytes decoded (MEM error: 2).
- Address wrap: req_addr + MAXB-1 beyond the ROM range is flagged by genrom via mem_error and reported as MEM.

Optional Feature:
- LEB128_FAST_EN defined: DECODE collapses into a single cycle. All MAXB bytes are decoded combinationally from the latched window, the first clear bit 7 is found with a priority encoder, and latency is a fixed 3 cycles.
- Undefined: iterative one-byte-per-cycle DECODE as above.
- Results, rsp_len and rsp_error are identical in both builds.

Decomposition:
- Package leb128_pkg:
  - state enum: IDLE, WAIT, DECODE, DONE
  - error codes: LEB_OK, LEB_MEM, LEB_TOO_LONG, LEB_OVERFLOW
  - constants: LEB_MAXB32=5, LEB_MAXB64=10
- Sub-module leb128_byte_step (combinational): inputs acc, shift, byte, is_last_allowed, signed, width. Outputs next acc, done, error. It is instantiated once in the iterative build and MAXB times in the fast build.

Test Plan:
- u32 bytes E5 8E 26 at addr 3 -> rsp_value=624485, rsp_len=3, rsp_error=0; rsp_valid asserts 5 cycles after accept (fast build: 3).
- s32 byte 7F -> rsp_value=0x00000000FFFFFFFF, rsp_len=1. s64 bytes C0 BB 78 -> rsp_value=-123456 (0xFFFFFFFFFFFE1DC0), rsp_len=3.
- u32 bytes FF FF FF FF 0F -> 0xFFFFFFFF, len 5, OK. Same with last byte 1F -> OVERFLOW, value 0. u32 bytes 80 80 80 80 80 -> TOO_LONG, len 5.
- upper_bound set below req_addr+MAXB-1 -> mem_error seen -> rsp_error=MEM, rsp_len=0, 2-cycle latency.
- Hold rsp_ready=0 for 4 cycles -> rsp_valid and all rsp fields stable and req_ready=0 throughout; release -> IDLE the next cycle.
- Assert reset mid-DECODE of a 10-byte u64 -> all outputs zero immediately (async); no response after release; next request decodes correctly.
